// File: rtl/m_mem_ctrl.sv
// m_mem_ctrl: M-stage data-memory request/ack controller with store lane steering and load extension.
// Define M_ALIGN_CHECK_EN to enable alignment-fault detection (m_exc); otherwise m_exc is tied low.
module m_mem_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_stall,
  output logic        m_done,
  output logic [31:0] m_rdata,
  output logic        m_exc,
  output logic        m_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  // state | meaning
  // IDLE  | waiting for a valid memory op in M
  // REQ   | mem_req high, waiting for mem_ack or the wait limit
  // DONE  | one-cycle completion pulse, pipeline released
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam int CW_RAW = $clog2(WAIT_MAX + 1);
  localparam int CW = (CW_RAW > 8) ? CW_RAW : 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    lane_q, lane_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_byteen_q, mem_byteen_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          m_done_q, m_done_d;
  logic [31:0]   m_rdata_q, m_rdata_d;
  logic          m_err_q, m_err_d;

  logic          is_load, is_store, is_mem, align_fault;
  logic [3:0]    be_new;
  logic [31:0]   wd_new;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;

  assign is_load  = (m_op >= OP_LW) && (m_op <= OP_LBU);
  assign is_store = (m_op >= OP_SW) && (m_op <= OP_SB);
  assign is_mem   = is_load | is_store;

`ifdef M_ALIGN_CHECK_EN
  logic m_exc_q, m_exc_d;
  assign align_fault = (((m_op == OP_LW) || (m_op == OP_SW)) && (m_addr[1:0] != 2'b00)) ||
                       (((m_op == OP_LH) || (m_op == OP_LHU) || (m_op == OP_SH)) && m_addr[0]);
  assign m_exc = m_exc_q;
`else
  assign align_fault = 1'b0;
  assign m_exc = 1'b0;
`endif

  always_comb begin
    be_new = 4'b1111;
    wd_new = m_wdata;
    case (m_op)
      OP_SH: begin
        be_new = 4'b0011 << {m_addr[1], 1'b0};
        wd_new = m_wdata << {m_addr[1], 4'b0000};
      end
      OP_SB: begin
        be_new = 4'b0001 << m_addr[1:0];
        wd_new = m_wdata << {m_addr[1:0], 3'b000};
      end
      default: ;
    endcase
  end

  // Lane of the captured request selects which byte/halfword of the returned word is used.
  assign ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (op_q)
      OP_LW:   ld_val = mem_rdata;
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'b0, ld_half};
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'b0, ld_byte};
      default: ld_val = 32'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    lane_d       = lane_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_byteen_d = mem_byteen_q;
    mem_wdata_d  = mem_wdata_q;
    m_done_d     = 1'b0;
    m_rdata_d    = 32'b0;
    m_err_d      = 1'b0;
`ifdef M_ALIGN_CHECK_EN
    m_exc_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (m_valid && is_mem) begin
          if (align_fault) begin
            state_d  = S_DONE;
            m_done_d = 1'b1;
`ifdef M_ALIGN_CHECK_EN
            m_exc_d  = 1'b1;
`endif
          end else begin
            state_d      = S_REQ;
            cnt_d        = '0;
            op_d         = m_op;
            lane_d       = m_addr[1:0];
            mem_req_d    = 1'b1;
            mem_we_d     = is_store;
            mem_addr_d   = {m_addr[31:2], 2'b00};
            mem_byteen_d = be_new;
            mem_wdata_d  = wd_new;
          end
        end
      end
      S_REQ: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (mem_ack) begin
          state_d   = S_DONE;
          m_done_d  = 1'b1;
          m_rdata_d = ld_val;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = S_DONE;
          m_done_d = 1'b1;
          m_err_d  = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 4'b0;
      lane_q       <= 2'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_byteen_q <= 4'b0;
      mem_wdata_q  <= 32'b0;
      m_done_q     <= 1'b0;
      m_rdata_q    <= 32'b0;
      m_err_q      <= 1'b0;
`ifdef M_ALIGN_CHECK_EN
      m_exc_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_byteen_q <= mem_byteen_d;
      mem_wdata_q  <= mem_wdata_d;
      m_done_q     <= m_done_d;
      m_rdata_q    <= m_rdata_d;
      m_err_q      <= m_err_d;
`ifdef M_ALIGN_CHECK_EN
      m_exc_q      <= m_exc_d;
`endif
    end
  end

  assign m_stall    = ~reset & (((state_q == S_IDLE) & m_valid & is_mem) | (state_q == S_REQ));
  assign m_done     = m_done_q;
  assign m_rdata    = m_rdata_q;
  assign m_err      = m_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_m_mem_ctrl.sv
// Testbench for m_mem_ctrl: scoreboard of expected completions checked on each m_done pulse.
module tb_m_mem_ctrl;
  localparam int WM = 4;

  logic        clk = 1'b0;
  logic        reset, m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_wdata;
  logic        m_stall, m_done, m_exc, m_err;
  logic [31:0] m_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  m_mem_ctrl #(.WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_stall(m_stall), .m_done(m_done), .m_rdata(m_rdata),
    .m_exc(m_exc), .m_err(m_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * int'(a));
    h = w >> (16 * int'(a[1]));
    case (op)
      4'd1:    return w;
      4'd2:    return {{16{h[15]}}, h[15:0]};
      4'd3:    return {16'h0000, h[15:0]};
      4'd4:    return {{24{b[7]}}, b[7:0]};
      4'd5:    return {24'h000000, b[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Completion monitor: every m_done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexp_done", 32'(m_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("sb.rdata", m_rdata, e.rdata);
        check_val("sb.exc", 32'(m_exc), 32'(e.exc));
        check_val("sb.err", 32'(m_err), 32'(e.err));
      end
    end
  end

  // Called #1 after a rising edge while the DUT is idle; ack_at is the REQ cycle (1-based) that acks, 0 = never.
  task automatic run_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                            input int exp_reqs, input logic [3:0] exp_be, input logic exp_we,
                            input logic chk_wd, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd, input logic exp_exc, input logic exp_err);
    int n;
    int reqs;
    exp_t e;
    logic [31:0] exp_addr;
    e.rdata = exp_rd;
    e.exc   = exp_exc;
    e.err   = exp_err;
    sb_q.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    m_valid = 1'b1;
    m_op    = op;
    m_addr  = addr;
    m_wdata = wdata;
    #1;
    check_val({tag, ".stall0"}, 32'(m_stall), 32'd1);
    @(posedge clk); #1;
    n = 1;
    reqs = 0;
    while (m_done !== 1'b1 && n <= 40) begin
      reqs++;
      check_val({tag, ".req"}, 32'(mem_req), 32'd1);
      check_val({tag, ".stall"}, 32'(m_stall), 32'd1);
      check_val({tag, ".addr"}, mem_addr, exp_addr);
      check_val({tag, ".be"}, 32'(mem_byteen), 32'(exp_be));
      check_val({tag, ".we"}, 32'(mem_we), 32'(exp_we));
      if (chk_wd) check_val({tag, ".wd"}, mem_wdata, exp_wd);
      mem_ack   = (n == ack_at);
      mem_rdata = (n == ack_at) ? rdata : $urandom();
      @(posedge clk); #1;
      n++;
    end
    mem_ack = 1'b0;
    check_val({tag, ".done"}, 32'(m_done), 32'd1);
    check_val({tag, ".reqs"}, 32'(reqs), 32'(exp_reqs));
    check_val({tag, ".stall_done"}, 32'(m_stall), 32'd0);
    check_val({tag, ".req_done"}, 32'(mem_req), 32'd0);
    m_valid = 1'b0;
    m_op    = 4'd0;
    @(posedge clk); #1;
    check_val({tag, ".pulse"}, 32'(m_done), 32'd0);
    check_val({tag, ".idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, w;
    reset     = 1'b1;
    m_valid   = 1'b0;
    m_op      = 4'd0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.stall", 32'(m_stall), 32'd0);
    check_val("rst.done", 32'(m_done), 32'd0);
    check_val("rst.req", 32'(mem_req), 32'd0);
    check_val("rst.we", 32'(mem_we), 32'd0);
    check_val("rst.addr", mem_addr, 32'h0);
    check_val("rst.be", 32'(mem_byteen), 32'd0);
    check_val("rst.wd", mem_wdata, 32'h0);
    check_val("rst.rdata", m_rdata, 32'h0);
    check_val("rst.err", 32'(m_err), 32'd0);
    check_val("rst.exc", 32'(m_exc), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // lb sign extension, ack in the first REQ cycle
    run_access("lb", 4'd4, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1, 1, 4'b1111, 1'b0,
               1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    // sh lane shift, ack on the 5th REQ cycle
    run_access("sh", 4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 5, 5, 4'b1100, 1'b1,
               1'b1, 32'hABCD_0000, 32'h0, 1'b0, 1'b0);
    run_access("sb", 4'd8, 32'h0000_0401, 32'h0000_00A5, 32'h0, 2, 2, 4'b0010, 1'b1,
               1'b1, 32'h0000_A500, 32'h0, 1'b0, 1'b0);
    run_access("sw", 4'd6, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 1, 1, 4'b1111, 1'b1,
               1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    // timeout: WAIT_MAX+1 REQ cycles with no ack
    run_access("tmo", 4'd1, 32'h0000_0100, 32'h0, 32'h0, 0, WM + 1, 4'b1111, 1'b0,
               1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    // ack on the timeout cycle wins
    run_access("coinc", 4'd3, 32'h0000_0002, 32'h0, 32'h8001_0000, WM + 1, WM + 1, 4'b1111, 1'b0,
               1'b0, 32'h0, 32'h0000_8001, 1'b0, 1'b0);
    // ops outside 1..8 are not memory ops
    m_valid = 1'b1;
    m_op    = 4'd11;
    #1;
    check_val("nop.stall", 32'(m_stall), 32'd0);
    @(posedge clk); #1;
    check_val("nop.req", 32'(mem_req), 32'd0);
    m_valid = 1'b0;
    m_op    = 4'd0;

`ifdef M_ALIGN_CHECK_EN
    run_access("align", 4'd1, 32'h0000_0001, 32'h0, 32'h0, 1, 0, 4'b1111, 1'b0,
               1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`else
    run_access("align", 4'd1, 32'h0000_0001, 32'h0, 32'hDEAD_BEEF, 1, 1, 4'b1111, 1'b0,
               1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
`endif

    // random aligned loads
    for (int i = 0; i < 10; i++) begin
      int ack;
      op  = 4'($urandom_range(1, 5));
      a   = $urandom();
      if (op == 4'd1) a[1:0] = 2'b00;
      else if (op == 4'd2 || op == 4'd3) a[0] = 1'b0;
      w   = $urandom();
      ack = $urandom_range(1, 3);
      run_access("rnd", op, a, 32'h0, w, ack, ack, 4'b1111, 1'b0, 1'b0, 32'h0,
                 ref_load(op, a[1:0], w), 1'b0, 1'b0);
    end

    // reset during REQ, then a late ack
    m_valid = 1'b1;
    m_op    = 4'd1;
    m_addr  = 32'h0000_0300;
    @(posedge clk); #1;
    check_val("mrst.req_on", 32'(mem_req), 32'd1);
    reset   = 1'b1;
    m_valid = 1'b0;
    m_op    = 4'd0;
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    check_val("mrst.req", 32'(mem_req), 32'd0);
    check_val("mrst.stall", 32'(m_stall), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check_val("mrst.done", 32'(m_done), 32'd0);
    check_val("mrst.req2", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check_val("mrst.done2", 32'(m_done), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/m_mem_ctrl.md
# m_mem_ctrl

M-stage data-memory access controller for the pipelined CPU. It turns the M-stage load/store request into a request/acknowledge transaction toward a variable-latency data memory. It generates byte enables and shifted write data, extracts and extends load data, and holds the pipeline with `m_stall` until the access completes, fails, or times out. It sits between the M-stage pipeline registers and the DM port; its `m_rdata` feeds the M→W register.

## Interface
- `WAIT_MAX`, default 255: maximum cycles spent waiting for `mem_ack` before the access is aborted.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m_valid` in 1: the M-stage instruction is valid.
- `m_op` in 4: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; codes 9–15 are treated as none.
- `m_addr` in 32: effective byte address.
- `m_wdata` in 32: store source (rt value).
- `m_stall` out 1: freezes F/D/E/M stages.
- `m_done` out 1: one-cycle pulse marking access completion.
- `m_rdata` out 32: extended load result, valid while `m_done`=1.
- `m_exc` out 1: alignment exception, valid with `m_done`.
- `m_err` out 1: timeout abort, valid with `m_done`.
- `mem_req` out 1: request to the memory.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word address, `{m_addr[31:2],2'b00}`.
- `mem_byteen` out 4: byte enables.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_ack` in 1: memory acknowledge.
- `mem_rdata` in 32: read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ when `m_valid` and the op is a memory op and there is no alignment fault.
- IDLE → DONE directly on an alignment fault. No request is issued in that case.
- REQ → DONE on `mem_ack`=1, or when the wait counter reaches `WAIT_MAX`.
- DONE → IDLE unconditionally.
- Wait counter: 8+ bits wide (sized for `WAIT_MAX`). Cleared on entry to REQ. Increments each REQ cycle without ack. Saturates and never wraps.
- `m_stall` = (IDLE & `m_valid` & memory op) | REQ. It is 0 in DONE, so the pipeline advances exactly at the end of DONE.
- `mem_req`=1 only in REQ. `mem_we`, `mem_addr`, `mem_byteen` and `mem_wdata` are held stable for the whole of REQ.
- `mem_ack` is ignored outside REQ.
- Byte enables:
  - sw and all loads: 4'b1111.
  - sh: 4'b0011 << (2·`m_addr[1]`).
  - sb: 4'b0001 << `m_addr[1:0]`.
- Store data: `mem_wdata` = `m_wdata` << (8·`m_addr[1:0]`) for sb, << (16·`m_addr[1]`) for sh, unshifted for sw.
- Load extraction uses the registered `mem_rdata`, captured on the ack edge:
  - lb/lbu: byte `m_addr[1:0]`, sign- or zero-extended.
  - lh/lhu: halfword `m_addr[1]`, sign- or zero-extended.
  - lw: full word.
- Stores, timeouts and faults return `m_rdata`=0.
- When the ack and the timeout condition coincide in the same cycle, the ack wins: `m_err`=0.
- Reset mid-access: next state is IDLE and `mem_req` drops. A late `mem_ack` is ignored.

## Timing
- Reset values: state IDLE, counter 0; every output is 0.
- Cycle 0: IDLE with a memory op, `m_stall`=1. Cycle 1: REQ.
- With ack in cycle k, DONE is at k+1: `m_done`=1, `m_stall`=0.
- Minimum latency is 3 cycles (ack in the first REQ cycle).
- Timeout: `m_err`=1 in DONE after `WAIT_MAX`+1 REQ cycles with no ack.
- Back-to-back memory ops: the next op starts from IDLE one cycle after DONE.

## Configuration
- `M_ALIGN_CHECK_EN` defined:
  - Faults are lw/sw with `m_addr[1:0]`≠0, and lh/lhu/sh with `m_addr[0]`=1.
  - On a fault the FSM goes IDLE → DONE with `m_exc`=1, `m_rdata`=0, and no request.
- `M_ALIGN_CHECK_EN` undefined:
  - `m_exc` is tied to 0 and the alignment check logic is absent.
  - Low address bits are ignored where unused; e.g. a misaligned lw reads the aligned word.

## Test plan
- Load byte with sign extension:
  - Stimulus: lb at `m_addr`=0x0000_1003, ack one cycle after req, `mem_rdata`=0x80FF_0000.
  - Required: `mem_addr`=0x0000_1000, `mem_byteen`=4'b1111; in DONE `m_rdata`=0xFFFF_FF80; `m_stall` high for exactly 2 cycles.
- Store halfword lane shift:
  - Stimulus: sh at 0x0000_2002 with `m_wdata`=0x1234_ABCD, ack after 5 cycles.
  - Required: `mem_byteen`=4'b1100, `mem_we`=1, `mem_wdata`=0xABCD_0000, all stable for 5 cycles; then `m_done`=1.
- Timeout:
  - Stimulus: `WAIT_MAX`=4, lw, never ack.
  - Required: `m_done`=1, `m_err`=1, `m_rdata`=0 after 5 REQ cycles; then IDLE.
- Ack and timeout coincide:
  - Stimulus: lhu at 0x0000_0002, `mem_rdata`=0x8001_0000, ack on the timeout cycle.
  - Required: `m_rdata`=0x0000_8001, `m_err`=0.
- Reset mid-access:
  - Stimulus: reset during REQ, then ack the next cycle.
  - Required: `mem_req`=0 and `m_stall`=0 after the reset edge, no `m_done` pulse.
- Alignment check (with `M_ALIGN_CHECK_EN`):
  - Stimulus: lw at 0x0000_0001.
  - Required: no `mem_req`, `m_exc`=1 with `m_done` in cycle 1.
  - Without the macro: `mem_req` is issued to 0x0000_0000.
